rst_seq_ctrl: RTL

//  Reset/clock sequencer behind the reset synchronizer, running on the system clk.

---
 rtl/rst_seq_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq_ctrl
//  Description : Merges reset requests, holds every reset domain for a minimum
//                time, then releases the domains one at a time at a fixed
//                spacing. Also selects between the RC and crystal clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module rst_seq_ctrl #(
    parameter int N_DOM     = 4,
    parameter int PULSE_MIN = 8,
    parameter int GAP_CYC   = 16,
    parameter int OSC_WAIT  = 64,
    parameter int CW        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_req,
    input  logic             wdt_req,
    input  logic             soft_req,
    input  logic             osc_ok,
    input  logic             sw_en,
    output logic [N_DOM-1:0] dom_rst_n,
    output logic             clk_sel,
    output logic             busy,
    output logic             done,
    output logic [3:0]       cause
);

    localparam int IW = $clog2(N_DOM + 1);

    localparam logic [CW-1:0] c_pulse_last = CW'(PULSE_MIN - 1);
    localparam logic [CW-1:0] c_gap_last   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] c_osc_last   = CW'(OSC_WAIT - 1);
    localparam logic [IW-1:0] c_last_idx   = IW'(N_DOM - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [CW-1:0]     r_stab;
    logic [N_DOM-1:0]  r_dom_rst_n;
    logic              r_clk_sel;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        r_cause;

    state_t            w_state_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [IW-1:0]     w_idx_nxt;
    logic [CW-1:0]     w_stab_nxt;
    logic [N_DOM-1:0]  w_dom_rst_n_nxt;
    logic              w_clk_sel_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [3:0]        w_cause_nxt;

    logic              w_osc_fail;
    logic [3:0]        w_req;
    logic [N_DOM-1:0]  w_rel_mask;

    // Losing the crystal while running from it is treated as a reset request.
    assign w_osc_fail = r_clk_sel & ~osc_ok;
    assign w_req      = {w_osc_fail, soft_req, wdt_req, ext_req};
    assign w_rel_mask = N_DOM'(1) << r_idx;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_stab_nxt      = r_stab;
        w_dom_rst_n_nxt = r_dom_rst_n;
        w_clk_sel_nxt   = r_clk_sel;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_cause_nxt     = r_cause;

        if (|w_req) begin
            w_state_nxt     = ST_ASSERT;
            w_cnt_nxt       = '0;
            w_idx_nxt       = '0;
            w_stab_nxt      = '0;
            w_dom_rst_n_nxt = '0;
            w_done_nxt      = 1'b0;
            w_busy_nxt      = 1'b1;
            // A request arriving during the hold accumulates causes and restarts it.
            w_cause_nxt     = (r_state == ST_ASSERT) ? (r_cause | w_req) : w_req;
            if (w_osc_fail) begin
                w_clk_sel_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_cnt == c_pulse_last) begin
                        w_cnt_nxt       = '0;
                        w_idx_nxt       = IW'(1);
                        w_dom_rst_n_nxt = r_dom_rst_n | N_DOM'(1);
                        if (N_DOM == 1) begin
                            w_state_nxt = ST_RUN;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = ST_RELEASE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == c_gap_last) begin
                        w_cnt_nxt       = '0;
                        w_idx_nxt       = r_idx + IW'(1);
                        w_dom_rst_n_nxt = r_dom_rst_n | w_rel_mask;
                        if (r_idx == c_last_idx) begin
                            w_state_nxt = ST_RUN;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!r_clk_sel) begin
                        if (osc_ok && sw_en) begin
                            if (r_stab == c_osc_last) begin
                                w_clk_sel_nxt = 1'b1;
                                w_stab_nxt    = '0;
                            end else begin
                                w_stab_nxt = r_stab + CW'(1);
                            end
                        end else begin
                            w_stab_nxt = '0;
                        end
                    end else if (!sw_en) begin
                        w_clk_sel_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_ASSERT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ASSERT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stab      <= '0;
            r_dom_rst_n <= '0;
            r_clk_sel   <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_cause     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_stab      <= w_stab_nxt;
            r_dom_rst_n <= w_dom_rst_n_nxt;
            r_clk_sel   <= w_clk_sel_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cause     <= w_cause_nxt;
        end
    end

    assign dom_rst_n = r_dom_rst_n;
    assign clk_sel   = r_clk_sel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cause     = r_cause;

endmodule
`default_nettype wire
